// File: rtl/window_calc_fsm_if.sv
// -----------------------------------------------------------------------------
// window_calc_fsm_if
// Peak-address stream between the peak detector and the window calculator.
//   pk_valid : source has a peak address this cycle
//   pk_ready : window calculator accepts the peak this cycle
//   pk_addr  : coarse peak bin address (NB bits) of the current pixel
//   pk_last  : marks the peak of the final pixel of the frame
// master = peak source, slave = window calculator.
// -----------------------------------------------------------------------------
interface window_calc_fsm_if #(
    parameter int NB = 8
) ();
    logic          pk_valid;
    logic          pk_ready;
    logic [NB-1:0] pk_addr;
    logic          pk_last;

    modport master (
        output pk_valid,
        output pk_addr,
        output pk_last,
        input  pk_ready
    );

    modport slave (
        input  pk_valid,
        input  pk_addr,
        input  pk_last,
        output pk_ready
    );
endinterface

// File: rtl/window_calc_fsm.sv
// -----------------------------------------------------------------------------
// window_calc_fsm
// Turns the coarse peak bin address of every pixel into a clamped fine-pass
// timestamp window [th_minus, th_positive] and stores it in a per-pixel table
// that the fine-pass data filter reads through a registered port.
// Ports:
//   clk         : system clock, rising edge
//   res         : asynchronous active-low reset
//   start       : one-cycle pulse, coarse histogram complete -> load peaks
//   pk          : peak stream (slave side of window_calc_fsm_if)
//   rd_pixel    : table read index
//   th_minus    : registered window lower bound of rd_pixel (0 if out of range)
//   th_positive : registered window upper bound of rd_pixel (0 if out of range)
//   win_valid   : table holds a complete, consistent window set
//   done        : one-cycle pulse when a table update completes
//   seq_err     : sticky, pk_last seen at the wrong pixel position
// -----------------------------------------------------------------------------
module window_calc_fsm #(
    parameter int NP        = 12,
    parameter int NB        = 8,
    parameter int SB        = 100,
    parameter int PIXEL_NUM = 200
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    window_calc_fsm_if.slave    pk,
    input  logic [7:0]          rd_pixel,
    output logic [NP-1:0]       th_minus,
    output logic [NP-1:0]       th_positive,
    output logic                win_valid,
    output logic                done,
    output logic                seq_err
);

    // UPPER = 2^NP-1 is the "no photon" marker, so windows top out at UPPER-1.
    localparam logic [NP:0]   UPPER_M1_W = (NP+1)'((2 ** NP) - 2);
    localparam logic [NP:0]   SB_W       = (NP+1)'(SB);
    localparam logic [NP-1:0] SB_N       = NP'(SB);
    localparam logic [NP-1:0] TWO_SB     = NP'(2 * SB);
    localparam logic [NP-1:0] HI_MAX     = NP'((2 ** NP) - 2);
    localparam logic [NP-1:0] LO_AT_TOP  = NP'((2 ** NP) - 2 - 2 * SB);
    localparam logic [7:0]    LAST_IDX   = 8'(PIXEL_NUM - 1);
    localparam logic [7:0]    PIX_NUM_B  = 8'(PIXEL_NUM);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;
    typedef enum logic [1:0] {CL_MID, CL_LO, CL_HI} clamp_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q;
    logic          flush_q;
    logic          win_valid_q;
    logic          seq_err_q;
    logic          hs;

    // Pipeline stage S1: centre, clamp decision and destination pixel.
    logic          s1_vld_q;
    logic [7:0]    s1_idx_q;
    logic [NP-1:0] s1_c_q;
    clamp_t        s1_sel_q;

    logic [NP-1:0] c_full;
    logic [NP:0]   c_ext;
    clamp_t        sel_d;
    logic [NP-1:0] win_lo_d, win_hi_d;

    logic [NP-1:0] tbl_lo_q [PIXEL_NUM];
    logic [NP-1:0] tbl_hi_q [PIXEL_NUM];
    logic [NP-1:0] rd_lo_q, rd_hi_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge res) begin
        if (!res) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (hs && (cnt_q == LAST_IDX)) state_d = S_FLUSH;
            // flush_q marks the second FLUSH cycle: S1 and S2 are empty by then.
            S_FLUSH: if (flush_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pk.pk_ready = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_LOAD:  pk.pk_ready = 1'b1;
            S_DONE:  done        = 1'b1;
            default: ;
        endcase
    end

    assign hs = pk.pk_valid && (state_q == S_LOAD);

    // ---------------- Control registers ----------------
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            win_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            flush_q <= (state_q == S_FLUSH) ? ~flush_q : 1'b0;
            if (state_q == S_IDLE && start) begin
                cnt_q       <= '0;
                win_valid_q <= 1'b0;
            end else if (hs) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == S_DONE) win_valid_q <= 1'b1;
            // pk_last must appear on exactly the final pixel's handshake.
            if (hs && (pk.pk_last != (cnt_q == LAST_IDX))) seq_err_q <= 1'b1;
        end
    end

    // ---------------- S1: centre and clamp decision ----------------
    assign c_full = {pk.pk_addr, {(NP-NB){1'b0}}};
    assign c_ext  = {1'b0, c_full};   // one guard bit so C+SB cannot wrap

    always_comb begin
        sel_d = CL_MID;
        if (c_ext + SB_W > UPPER_M1_W) sel_d = CL_HI;
        else if (c_ext <= SB_W)        sel_d = CL_LO;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_c_q   <= '0;
            s1_sel_q <= CL_MID;
        end else begin
            s1_vld_q <= hs;
            if (hs) begin
                s1_idx_q <= cnt_q;
                s1_c_q   <= c_full;
                s1_sel_q <= sel_d;
            end
        end
    end

    // ---------------- S2: window bounds and table write ----------------
    always_comb begin
        win_lo_d = s1_c_q - SB_N;
        win_hi_d = s1_c_q + SB_N;
        unique case (s1_sel_q)
            CL_HI: begin
                win_lo_d = LO_AT_TOP;
                win_hi_d = HI_MAX;
            end
            CL_LO: begin
                win_lo_d = '0;
                win_hi_d = TWO_SB;
            end
            default: ;
        endcase
    end

    // Reset leaves every pixel with the full-range window so the filter passes
    // everything until a real set is loaded.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < PIXEL_NUM; i++) begin
                tbl_lo_q[i] <= '0;
                tbl_hi_q[i] <= HI_MAX;
            end
        end else if (s1_vld_q) begin
            tbl_lo_q[s1_idx_q] <= win_lo_d;
            tbl_hi_q[s1_idx_q] <= win_hi_d;
        end
    end

    // ---------------- Registered read port ----------------
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rd_lo_q <= '0;
            rd_hi_q <= '0;
        end else if (rd_pixel < PIX_NUM_B) begin
            rd_lo_q <= tbl_lo_q[rd_pixel];
            rd_hi_q <= tbl_hi_q[rd_pixel];
        end else begin
            rd_lo_q <= '0;
            rd_hi_q <= '0;
        end
    end

    assign th_minus    = rd_lo_q;
    assign th_positive = rd_hi_q;
    assign win_valid   = win_valid_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_window_calc_fsm.sv
module tb_window_calc_fsm;
    localparam int NP        = 12;
    localparam int NB        = 8;
    localparam int SB        = 100;
    localparam int PIXEL_NUM = 200;

    logic          clk   = 1'b0;
    logic          res   = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rd_pixel = 8'd0;
    logic [NP-1:0] th_minus, th_positive;
    logic          win_valid, done, seq_err;

    window_calc_fsm_if #(.NB(NB)) pk_if ();

    window_calc_fsm #(.NP(NP), .NB(NB), .SB(SB), .PIXEL_NUM(PIXEL_NUM)) dut (
        .clk         (clk),
        .res         (res),
        .start       (start),
        .pk          (pk_if),
        .rd_pixel    (rd_pixel),
        .th_minus    (th_minus),
        .th_positive (th_positive),
        .win_valid   (win_valid),
        .done        (done),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected table contents after the last completed load (or reset).
    int mdl_lo [PIXEL_NUM];
    int mdl_hi [PIXEL_NUM];
    bit exp_seq = 1'b0;

    logic       rd_chk    = 1'b0;
    logic       rd_lat_ok = 1'b0;
    logic [7:0] rd_lat    = 8'd0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Window as a clamped lower edge: slide [C-SB, C+SB] inside [0, UPPER-1].
    function automatic int win_lo(input int addr);
        int lo;
        int top;
        lo  = addr * (2 ** (NP - NB)) - SB;
        top = (2 ** NP) - 2 - 2 * SB;
        if (lo < 0)   lo = 0;
        if (lo > top) lo = top;
        return lo;
    endfunction

    function automatic int gen_addr(input int sel, input int i);
        if (sel == 0) begin
            case (i)
                0: return 0;
                1: return 128;
                2: return 255;
                3: return 6;
                4: return 7;
                default: return 128;
            endcase
        end
        return (i * 37 + 5) % 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PIXEL_NUM; i++) begin
            mdl_lo[i] = 0;
            mdl_hi[i] = (2 ** NP) - 2;
        end
    endtask

    task automatic model_fill(input int sel);
        for (int i = 0; i < PIXEL_NUM; i++) begin
            mdl_lo[i] = win_lo(gen_addr(sel, i));
            mdl_hi[i] = mdl_lo[i] + 2 * SB;
        end
    endtask

    // Read-port compare: value seen one cycle after the index was presented.
    always @(posedge clk) begin
        rd_lat    <= rd_pixel;
        rd_lat_ok <= rd_chk;
    end

    always @(negedge clk) begin
        if (rd_lat_ok) begin
            if (rd_lat >= 8'(PIXEL_NUM)) begin
                chk($sformatf("rd_lo[%0d]", rd_lat), th_minus, 0);
                chk($sformatf("rd_hi[%0d]", rd_lat), th_positive, 0);
            end else begin
                chk($sformatf("rd_lo[%0d]", rd_lat), th_minus, mdl_lo[rd_lat]);
                chk($sformatf("rd_hi[%0d]", rd_lat), th_positive, mdl_hi[rd_lat]);
            end
        end
    end

    // All tasks below start and end at posedge+1.
    task automatic readback();
        rd_chk = 1'b1;
        for (int p = 0; p < PIXEL_NUM + 2; p++) begin
            rd_pixel = 8'(p);
            @(posedge clk); #1;
        end
        rd_pixel = 8'd255;
        @(posedge clk); #1;
        rd_chk = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic read_expect(input int p, input int lo, input int hi);
        rd_pixel = 8'(p);
        @(posedge clk); #1;
        chk($sformatf("lit_lo[%0d]", p), th_minus, lo);
        chk($sformatf("lit_hi[%0d]", p), th_positive, hi);
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_ready"}, pk_if.pk_ready, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_th_minus"}, th_minus, 0);
        chk({tag, "_th_positive"}, th_positive, 0);
    endtask

    task automatic load(input bit gap, input bit extra_start, input int last_pos,
                        input int rst_at, input int sel);
        int i;
        int cyc;
        bit v;
        // pk_valid with pk_last in IDLE must be ignored (would corrupt count/seq_err)
        start = 1'b1;
        pk_if.pk_valid = 1'b1;
        pk_if.pk_addr  = 8'd99;
        pk_if.pk_last  = 1'b1;
        @(negedge clk);
        chk("ready_idle", pk_if.pk_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("win_valid_drop", win_valid, 0);
        if (last_pos != PIXEL_NUM - 1) exp_seq = 1'b1;
        i = 0;
        cyc = 0;
        while (i < PIXEL_NUM) begin
            v = !(gap && (cyc % 2 == 1));
            if (v && i == rst_at) begin
                res = 1'b0;
                pk_if.pk_valid = 1'b0;
                @(negedge clk);
                reset_outputs_check("midreset");
                @(posedge clk); #1;
                res = 1'b1;
                exp_seq = 1'b0;
                model_reset();
                return;
            end
            pk_if.pk_valid = v;
            pk_if.pk_addr  = 8'(gen_addr(sel, i));
            pk_if.pk_last  = (i == last_pos);
            start = extra_start && (i == 50);
            @(negedge clk);
            chk("ready_load", pk_if.pk_ready, 1);
            @(posedge clk); #1;
            if (v) begin
                if (i == last_pos && last_pos != PIXEL_NUM - 1) chk("seq_err_early", seq_err, 1);
                i++;
            end
            cyc++;
        end
        // Keep offering (with pk_last) after the final handshake: must not be taken.
        pk_if.pk_last = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            start = extra_start && (k == 1 || k == 3);
            @(negedge clk);
            chk($sformatf("done_k%0d", k), done, (k == 3) ? 1 : 0);
            chk($sformatf("ready_post_k%0d", k), pk_if.pk_ready, 0);
            if (k == 4) chk("win_valid_set", win_valid, 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        pk_if.pk_valid = 1'b0;
        pk_if.pk_last  = 1'b0;
        chk("seq_err_end", seq_err, exp_seq ? 1 : 0);
        model_fill(sel);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        pk_if.pk_valid = 1'b0;
        pk_if.pk_addr  = 8'd0;
        pk_if.pk_last  = 1'b0;
        model_reset();

        // Pin the model to hand-computed windows.
        chk("model_addr0", win_lo(0), 0);
        chk("model_addr128", win_lo(128), 1948);
        chk("model_addr255", win_lo(255), 3894);
        chk("model_addr7", win_lo(7), 12);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_outputs_check("reset");
        @(posedge clk); #1;
        res = 1'b1;
        read_expect(0, 0, 4094);
        chk("reset_win_valid", win_valid, 0);
        chk("reset_seq_err", seq_err, 0);
        readback();

        // Back-to-back load of the reference pattern.
        load(1'b0, 1'b0, PIXEL_NUM - 1, -1, 0);
        read_expect(0, 0, 200);
        read_expect(1, 1948, 2148);
        read_expect(2, 3894, 4094);
        read_expect(3, 0, 200);
        read_expect(4, 12, 212);
        read_expect(200, 0, 0);
        chk("load1_win_valid", win_valid, 1);
        readback();

        // Different pattern with pk_last misplaced on pixel 10.
        load(1'b0, 1'b0, 10, -1, 1);
        readback();

        // Reference pattern again, gapped valid, stray start pulses.
        load(1'b1, 1'b1, PIXEL_NUM - 1, -1, 0);
        read_expect(2, 3894, 4094);
        read_expect(4, 12, 212);
        readback();

        // Reset in the middle of loading.
        load(1'b0, 1'b0, PIXEL_NUM - 1, 50, 1);
        chk("after_midreset_seq_err", seq_err, 0);
        readback();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
